// File: rtl/cp0_unit_pkg.sv
// Shared CP0 definitions: register indices, field positions, exception codes and trap vector.
package cp0_defs;

   localparam logic [4:0] CP0_SR    = 5'd12;
   localparam logic [4:0] CP0_CAUSE = 5'd13;
   localparam logic [4:0] CP0_EPC   = 5'd14;

   localparam int unsigned IM_LSB  = 10;
   localparam int unsigned EXL_BIT = 1;
   localparam int unsigned IE_BIT  = 0;
   localparam int unsigned BD_BIT  = 31;
   localparam int unsigned IP_LSB  = 10;
   localparam int unsigned EXC_LSB = 2;

   typedef enum logic [4:0] {
      EXC_INT     = 5'd0,
      EXC_ADEL    = 5'd4,
      EXC_ADES    = 5'd5,
      EXC_SYSCALL = 5'd8,
      EXC_RI      = 5'd10,
      EXC_OV      = 5'd12
   } exc_code_e;

   localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;

   // A delay-slot victim returns to its branch, one word earlier.
   function automatic logic [31:0] epc_target(input logic [31:0] vpc, input logic bd);
      logic [31:0] aligned;
      aligned = vpc & ~32'd3;
      return bd ? aligned - 32'd4 : aligned;
   endfunction

endpackage

// File: rtl/cp0_req_gen.sv
// Combinational trap request: interrupts outrank exceptions, nothing nests while EXL is set.
module cp0_req_gen
   import cp0_defs::*;
#(
   parameter int unsigned HWINT_W = 6
) (
   input  logic               ie,
   input  logic               exl,
   input  logic [HWINT_W-1:0] im,
   input  logic [HWINT_W-1:0] hw_int,
   input  logic [4:0]         exc_code,
   output logic               int_req,
   output logic               exc_req,
   output logic               req
);

   assign int_req = ie & ~exl & (|(hw_int & im));
   assign exc_req = ~exl & (exc_code != EXC_INT);
   assign req     = int_req | exc_req;

endmodule

// File: rtl/cp0_unit.sv
// Coprocessor 0: holds SR/Cause/EPC, raises the trap request and serves mfc0/mtc0/eret.
module cp0_unit
   import cp0_defs::*;
#(
   parameter int unsigned HWINT_W = 6,
   parameter logic [31:0] SR_RST  = 32'h0,
   parameter logic [31:0] EPC_RST = 32'h0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               en,
   input  logic [4:0]         CP0Add,
   input  logic [31:0]        CP0In,
   input  logic [31:0]        VPC,
   input  logic               BDIn,
   input  logic [4:0]         ExcCodeIn,
   input  logic [HWINT_W-1:0] HWInt,
   input  logic               EXLClr,
   output logic [31:0]        CP0Out,
   output logic [31:0]        EPCOut,
   output logic               Req
);

   logic [HWINT_W-1:0] im;
   logic [HWINT_W-1:0] ip;
   logic               exl;
   logic               ie;
   logic               bd;
   logic [4:0]         exc_code;
   logic [31:0]        epc;

   logic               int_req;
   logic               exc_req;
   logic               raw_req;

   cp0_req_gen #(
      .HWINT_W (HWINT_W)
   ) u_req_gen (
      .ie       (ie),
      .exl      (exl),
      .im       (im),
      .hw_int   (HWInt),
      .exc_code (ExcCodeIn),
      .int_req  (int_req),
      .exc_req  (exc_req),
      .req      (raw_req)
   );

   assign Req    = raw_req & ~reset;
   assign EPCOut = epc;

   always_ff @(posedge clk) begin
      if (reset) begin
         im       <= SR_RST[IM_LSB +: HWINT_W];
         exl      <= SR_RST[EXL_BIT];
         ie       <= SR_RST[IE_BIT];
         bd       <= 1'b0;
         ip       <= '0;
         exc_code <= '0;
         epc      <= EPC_RST;
      end else begin
         ip <= HWInt;
         if (Req) begin
            exl      <= 1'b1;
            bd       <= BDIn;
            exc_code <= int_req ? EXC_INT : ExcCodeIn;
            epc      <= epc_target(VPC, BDIn);
         end else begin
            if (en && CP0Add == CP0_SR) begin
               im  <= CP0In[IM_LSB +: HWINT_W];
               exl <= CP0In[EXL_BIT];
               ie  <= CP0In[IE_BIT];
            end
            if (en && CP0Add == CP0_EPC) begin
               epc <= CP0In;
            end
            // Placed after the SR write so eret's clear wins when both land together.
            if (EXLClr) begin
               exl <= 1'b0;
            end
         end
      end
   end

   always_comb begin
      CP0Out = '0;
      case (CP0Add)
         CP0_SR: begin
            CP0Out[IM_LSB +: HWINT_W] = im;
            CP0Out[EXL_BIT]           = exl;
            CP0Out[IE_BIT]            = ie;
         end
         CP0_CAUSE: begin
            CP0Out[BD_BIT]            = bd;
            CP0Out[IP_LSB +: HWINT_W] = ip;
            CP0Out[EXC_LSB +: 5]      = exc_code;
         end
         CP0_EPC: CP0Out = epc;
         default: CP0Out = '0;
      endcase
   end

endmodule

// File: tb/tb_cp0_unit.sv
// Directed self-checking bench for cp0_unit with hand-computed expectations.
module tb_cp0_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        en;
   logic [4:0]  CP0Add;
   logic [31:0] CP0In;
   logic [31:0] VPC;
   logic        BDIn;
   logic [4:0]  ExcCodeIn;
   logic [5:0]  HWInt;
   logic        EXLClr;
   logic [31:0] CP0Out;
   logic [31:0] EPCOut;
   logic        Req;

   int n_assert = 0;
   int n_fail   = 0;

   cp0_unit #(
      .HWINT_W (6),
      .SR_RST  (32'h0),
      .EPC_RST (32'h0)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .CP0Add    (CP0Add),
      .CP0In     (CP0In),
      .VPC       (VPC),
      .BDIn      (BDIn),
      .ExcCodeIn (ExcCodeIn),
      .HWInt     (HWInt),
      .EXLClr    (EXLClr),
      .CP0Out    (CP0Out),
      .EPCOut    (EPCOut),
      .Req       (Req)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [4:0] a, input string tag, input logic [31:0] exp);
      CP0Add = a;
      #1;
      chk(tag, CP0Out, exp);
   endtask

   initial begin
      reset = 1'b1; en = 1'b0; CP0Add = 5'd0; CP0In = '0; VPC = '0;
      BDIn = 1'b0; ExcCodeIn = 5'd10; HWInt = '0; EXLClr = 1'b0;

      // Reset held two cycles with a pending exception code
      tick(); tick();
      chk("reset_req", {31'b0, Req}, 32'h0);
      rd(5'd12, "reset_sr", 32'h0);
      rd(5'd13, "reset_cause", 32'h0);
      rd(5'd14, "reset_epc_rd", 32'h0);
      chk("reset_epcout", EPCOut, 32'h0);

      // Overflow exception
      reset = 1'b0; ExcCodeIn = 5'd12; VPC = 32'h3010; BDIn = 1'b0;
      #1;
      chk("ov_req", {31'b0, Req}, 32'h1);
      tick();
      ExcCodeIn = 5'd0;
      chk("ov_epc", EPCOut, 32'h3010);
      rd(5'd13, "ov_cause", 32'h30);
      rd(5'd12, "ov_sr_exl", 32'h2);
      ExcCodeIn = 5'd4; #1;
      chk("nested_req", {31'b0, Req}, 32'h0);
      ExcCodeIn = 5'd0;

      // eret
      EXLClr = 1'b1; tick(); EXLClr = 1'b0;
      rd(5'd12, "eret_sr", 32'h0);

      // Delay-slot exception
      ExcCodeIn = 5'd4; VPC = 32'h3024; BDIn = 1'b1; #1;
      chk("bd_req", {31'b0, Req}, 32'h1);
      tick();
      ExcCodeIn = 5'd0; BDIn = 1'b0;
      chk("bd_epc", EPCOut, 32'h3020);
      rd(5'd13, "bd_cause", 32'h8000_0010);
      EXLClr = 1'b1; tick(); EXLClr = 1'b0;

      // mtc0 SR with IE and IM[10], then interrupt alongside syscall
      en = 1'b1; CP0Add = 5'd12; CP0In = 32'h0000_0401; tick(); en = 1'b0;
      rd(5'd12, "mtc0_sr", 32'h401);
      HWInt = 6'b000001; ExcCodeIn = 5'd8; VPC = 32'h3030; #1;
      chk("int_req", {31'b0, Req}, 32'h1);
      tick();
      rd(5'd13, "int_cause", 32'h400);
      chk("int_epc", EPCOut, 32'h3030);
      chk("int_exl_blocks", {31'b0, Req}, 32'h0);
      HWInt = '0; ExcCodeIn = 5'd0;
      EXLClr = 1'b1; tick(); EXLClr = 1'b0;

      // IE=0: interrupt masked, exception still traps
      en = 1'b1; CP0Add = 5'd12; CP0In = 32'h0000_0400; tick(); en = 1'b0;
      HWInt = 6'b000001; #1;
      chk("ie0_int_req", {31'b0, Req}, 32'h0);
      ExcCodeIn = 5'd8; VPC = 32'h3040; #1;
      chk("ie0_exc_req", {31'b0, Req}, 32'h1);
      tick();
      rd(5'd13, "ie0_cause", 32'h420);
      chk("ie0_epc", EPCOut, 32'h3040);
      HWInt = '0; ExcCodeIn = 5'd0;
      EXLClr = 1'b1; tick(); EXLClr = 1'b0;

      // mtc0 EPC, then Cause write ignored
      en = 1'b1; CP0Add = 5'd14; CP0In = 32'h3100; tick();
      chk("mtc0_epc", EPCOut, 32'h3100);
      CP0Add = 5'd13; CP0In = 32'hFFFF_FFFF; tick(); en = 1'b0;
      rd(5'd13, "cause_ro", 32'h20);
      rd(5'd15, "undef_addr", 32'h0);

      // Trap overrides a same-cycle SR write
      ExcCodeIn = 5'd5; VPC = 32'h3052; en = 1'b1; CP0Add = 5'd12; CP0In = 32'h0; #1;
      chk("sim_req", {31'b0, Req}, 32'h1);
      tick();
      en = 1'b0; ExcCodeIn = 5'd0;
      rd(5'd12, "sim_sr", 32'h402);
      chk("sim_epc", EPCOut, 32'h3050);
      rd(5'd13, "sim_cause", 32'h14);

      // Reset during a trap
      EXLClr = 1'b1; tick(); EXLClr = 1'b0;
      ExcCodeIn = 5'd12; HWInt = 6'b000001; reset = 1'b1; #1;
      chk("rst_trap_req", {31'b0, Req}, 32'h0);
      tick();
      reset = 1'b0; ExcCodeIn = 5'd0; HWInt = '0;
      rd(5'd12, "rst_trap_sr", 32'h0);
      rd(5'd13, "rst_trap_cause", 32'h0);
      chk("rst_trap_epc", EPCOut, 32'h0);

      // mtc0 SR and eret together: write applies, then EXL clears
      en = 1'b1; EXLClr = 1'b1; CP0Add = 5'd12; CP0In = 32'h0000_0403; tick();
      en = 1'b0; EXLClr = 1'b0;
      rd(5'd12, "wr_and_eret_sr", 32'h401);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
